// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - Y86-64 pipeline stage register with stall/bubble; PIPE_REG_PERF_EN adds stall/bubble counters
module pipe_stage_reg #(
  parameter int         WORD_W    = 64,
  parameter int         REG_W     = 4,
  parameter int         STAT_W    = 3,
  parameter logic [3:0] NOP_ICODE = 4'h1,
  parameter logic [2:0] BUB_STAT  = 3'h1,
  parameter logic [3:0] RNONE     = 4'hF
`ifdef PIPE_REG_PERF_EN
  , parameter int       CNT_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              bubble,
  input  logic [STAT_W-1:0] in_stat,
  input  logic [3:0]        in_icode,
  input  logic [3:0]        in_ifun,
  input  logic [WORD_W-1:0] in_valC,
  input  logic [WORD_W-1:0] in_valA,
  input  logic [WORD_W-1:0] in_valB,
  input  logic [REG_W-1:0]  in_destE,
  input  logic [REG_W-1:0]  in_destM,
  input  logic [REG_W-1:0]  in_srcA,
  input  logic [REG_W-1:0]  in_srcB,
  output logic [STAT_W-1:0] out_stat,
  output logic [3:0]        out_icode,
  output logic [3:0]        out_ifun,
  output logic [WORD_W-1:0] out_valC,
  output logic [WORD_W-1:0] out_valA,
  output logic [WORD_W-1:0] out_valB,
  output logic [REG_W-1:0]  out_destE,
  output logic [REG_W-1:0]  out_destM,
  output logic [REG_W-1:0]  out_srcA,
  output logic [REG_W-1:0]  out_srcB,
  output logic              out_bubble,
`ifdef PIPE_REG_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              ctl_err
);

  // Nop bundle shared by reset and bubble injection
  localparam logic [STAT_W-1:0] NOP_STAT = STAT_W'(BUB_STAT);
  localparam logic [REG_W-1:0]  NOP_REG  = REG_W'(RNONE);

  logic [STAT_W-1:0] stat_q,  stat_d;
  logic [3:0]        icode_q, icode_d;
  logic [3:0]        ifun_q,  ifun_d;
  logic [WORD_W-1:0] valc_q,  valc_d;
  logic [WORD_W-1:0] vala_q,  vala_d;
  logic [WORD_W-1:0] valb_q,  valb_d;
  logic [REG_W-1:0]  deste_q, deste_d;
  logic [REG_W-1:0]  destm_q, destm_d;
  logic [REG_W-1:0]  srca_q,  srca_d;
  logic [REG_W-1:0]  srcb_q,  srcb_d;
  logic              bub_q,   bub_d;
  logic              err_q,   err_d;

  // Next bundle: bubble beats stall beats load; a stall+bubble clash is remembered
  always_comb begin
    stat_d  = stat_q;
    icode_d = icode_q;
    ifun_d  = ifun_q;
    valc_d  = valc_q;
    vala_d  = vala_q;
    valb_d  = valb_q;
    deste_d = deste_q;
    destm_d = destm_q;
    srca_d  = srca_q;
    srcb_d  = srcb_q;
    bub_d   = bub_q;
    err_d   = err_q;
    if (bubble) begin
      stat_d  = NOP_STAT;
      icode_d = NOP_ICODE;
      ifun_d  = 4'h0;
      valc_d  = '0;
      vala_d  = '0;
      valb_d  = '0;
      deste_d = NOP_REG;
      destm_d = NOP_REG;
      srca_d  = NOP_REG;
      srcb_d  = NOP_REG;
      bub_d   = 1'b1;
      err_d   = err_q | stall;
    end else if (!stall) begin
      stat_d  = in_stat;
      icode_d = in_icode;
      ifun_d  = in_ifun;
      valc_d  = in_valC;
      vala_d  = in_valA;
      valb_d  = in_valB;
      deste_d = in_destE;
      destm_d = in_destM;
      srca_d  = in_srcA;
      srcb_d  = in_srcB;
      bub_d   = 1'b0;
    end
  end

  // Stage flops; reset loads the nop bundle and clears the error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q  <= NOP_STAT;
      icode_q <= NOP_ICODE;
      ifun_q  <= 4'h0;
      valc_q  <= '0;
      vala_q  <= '0;
      valb_q  <= '0;
      deste_q <= NOP_REG;
      destm_q <= NOP_REG;
      srca_q  <= NOP_REG;
      srcb_q  <= NOP_REG;
      bub_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      stat_q  <= stat_d;
      icode_q <= icode_d;
      ifun_q  <= ifun_d;
      valc_q  <= valc_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
      deste_q <= deste_d;
      destm_q <= destm_d;
      srca_q  <= srca_d;
      srcb_q  <= srcb_d;
      bub_q   <= bub_d;
      err_q   <= err_d;
    end
  end

  assign out_stat   = stat_q;
  assign out_icode  = icode_q;
  assign out_ifun   = ifun_q;
  assign out_valC   = valc_q;
  assign out_valA   = vala_q;
  assign out_valB   = valb_q;
  assign out_destE  = deste_q;
  assign out_destM  = destm_q;
  assign out_srcA   = srca_q;
  assign out_srcB   = srcb_q;
  assign out_bubble = bub_q;
  assign ctl_err    = err_q;

`ifdef PIPE_REG_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  // Saturating counters: held cycles only count when no bubble overrides the stall
  always_comb begin
    scnt_d = scnt_q;
    bcnt_d = bcnt_q;
    if (stall && !bubble && (scnt_q != '1)) scnt_d = scnt_q + CNT_ONE;
    if (bubble && (bcnt_q != '1))           bcnt_d = bcnt_q + CNT_ONE;
  end

  // Counter flops, cleared by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      scnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      scnt_q <= scnt_d;
      bcnt_q <= bcnt_d;
    end
  end

  assign stall_cnt  = scnt_q;
  assign bubble_cnt = bcnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed bench for pipe_stage_reg; PIPE_REG_PERF_EN also checks counters (CNT_W=4)
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, stall, bubble;
  logic [2:0]  in_stat, out_stat;
  logic [3:0]  in_icode, out_icode, in_ifun, out_ifun;
  logic [63:0] in_valC, in_valA, in_valB, out_valC, out_valA, out_valB;
  logic [3:0]  in_destE, in_destM, in_srcA, in_srcB;
  logic [3:0]  out_destE, out_destM, out_srcA, out_srcB;
  logic        out_bubble, ctl_err;
`ifdef PIPE_REG_PERF_EN
  logic [3:0]  stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .WORD_W(64), .REG_W(4), .STAT_W(3),
    .NOP_ICODE(4'h1), .BUB_STAT(3'h1), .RNONE(4'hF)
`ifdef PIPE_REG_PERF_EN
    , .CNT_W(4)
`endif
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
    .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
    .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
    .in_destE(in_destE), .in_destM(in_destM), .in_srcA(in_srcA), .in_srcB(in_srcB),
    .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
    .out_valC(out_valC), .out_valA(out_valA), .out_valB(out_valB),
    .out_destE(out_destE), .out_destM(out_destM), .out_srcA(out_srcA), .out_srcB(out_srcB),
    .out_bubble(out_bubble),
`ifdef PIPE_REG_PERF_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .ctl_err(ctl_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and sample 1 time unit later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sb);
    in_stat = st; in_icode = ic; in_ifun = fn;
    in_valC = c;  in_valA = a;   in_valB = b;
    in_destE = de; in_destM = dm; in_srcA = sa; in_srcB = sb;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0;
    drive(3'h0, 4'h0, 4'h0, 64'h0, 64'h0, 64'h0, 4'h0, 4'h0, 4'h0, 4'h0);

    // reset
    tick();
    check("rst_icode",  out_icode, 64'h1);
    check("rst_stat",   out_stat, 64'h1);
    check("rst_destE",  out_destE, 64'hF);
    check("rst_srcB",   out_srcB, 64'hF);
    check("rst_valA",   out_valA, 64'h0);
    check("rst_bubble", out_bubble, 64'h1);
    check("rst_err",    ctl_err, 64'h0);
`ifdef PIPE_REG_PERF_EN
    check("rst_scnt",   stall_cnt, 64'h0);
    check("rst_bcnt",   bubble_cnt, 64'h0);
`endif

    // plain load
    reset = 1'b0;
    drive(3'h1, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, 4'hF, 4'h1, 4'h2);
    tick();
    check("ld_icode",  out_icode, 64'h6);
    check("ld_valA",   out_valA, 64'h5);
    check("ld_valB",   out_valB, 64'h7);
    check("ld_destE",  out_destE, 64'h3);
    check("ld_bubble", out_bubble, 64'h0);

    // full-width load of every field
    drive(3'h2, 4'h3, 4'h5, 64'hDEADBEEF_CAFEF00D, 64'hFFFFFFFF_FFFFFFFF, 64'h80000000_00000001,
          4'h0, 4'hA, 4'h2, 4'h9);
    tick();
    check("ld2_stat",  out_stat, 64'h2);
    check("ld2_ifun",  out_ifun, 64'h5);
    check("ld2_valC",  out_valC, 64'hDEADBEEF_CAFEF00D);
    check("ld2_valA",  out_valA, 64'hFFFFFFFF_FFFFFFFF);
    check("ld2_valB",  out_valB, 64'h80000000_00000001);
    check("ld2_destE", out_destE, 64'h0);
    check("ld2_destM", out_destM, 64'hA);
    check("ld2_srcA",  out_srcA, 64'h2);
    check("ld2_srcB",  out_srcB, 64'h9);

    // load icode=6 then stall three cycles with changing inputs
    drive(3'h1, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, 4'hF, 4'h1, 4'h2);
    tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'h4, 4'h7 + 4'(i), 4'h3, 64'h99, 64'h10 + 64'(i), 64'h20, 4'h4, 4'h5, 4'h6, 4'h7);
      tick();
    end
    check("stl_icode",  out_icode, 64'h6);
    check("stl_valA",   out_valA, 64'h5);
    check("stl_stat",   out_stat, 64'h1);
    check("stl_destE",  out_destE, 64'h3);
    check("stl_bubble", out_bubble, 64'h0);
`ifdef PIPE_REG_PERF_EN
    check("stl_scnt",   stall_cnt, 64'h3);
`endif

    // bubble after a valid load
    stall = 1'b0; bubble = 1'b1;
    tick();
    check("bub_icode",  out_icode, 64'h1);
    check("bub_destM",  out_destM, 64'hF);
    check("bub_valA",   out_valA, 64'h0);
    check("bub_bubble", out_bubble, 64'h1);
    check("bub_err",    ctl_err, 64'h0);
`ifdef PIPE_REG_PERF_EN
    check("bub_bcnt",   bubble_cnt, 64'h1);
`endif

    // stalling a bubble keeps it marked as a bubble
    bubble = 1'b0; stall = 1'b1;
    tick();
    check("stlbub_bubble", out_bubble, 64'h1);
    check("stlbub_icode",  out_icode, 64'h1);
`ifdef PIPE_REG_PERF_EN
    check("stlbub_scnt",   stall_cnt, 64'h4);
`endif

    // stall and bubble together: nop wins, error latched
    bubble = 1'b1;
    tick();
    check("sb_icode",  out_icode, 64'h1);
    check("sb_valA",   out_valA, 64'h0);
    check("sb_bubble", out_bubble, 64'h1);
    check("sb_err",    ctl_err, 64'h1);
`ifdef PIPE_REG_PERF_EN
    check("sb_scnt",   stall_cnt, 64'h4);
    check("sb_bcnt",   bubble_cnt, 64'h2);
`endif

    // error stays set through ten ordinary loads
    stall = 1'b0; bubble = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(3'h1, 4'(i), 4'h2, 64'h0, 64'(i) * 64'h3, 64'h0, 4'h1, 4'h2, 4'h3, 4'h4);
      tick();
    end
    check("sticky_err",   ctl_err, 64'h1);
    check("sticky_icode", out_icode, 64'h9);
    check("sticky_valA",  out_valA, 64'h1B);

    // reset together with stall and bubble: reset result only
    reset = 1'b1; stall = 1'b1; bubble = 1'b1;
    tick();
    check("rsb_err",    ctl_err, 64'h0);
    check("rsb_icode",  out_icode, 64'h1);
    check("rsb_bubble", out_bubble, 64'h1);
`ifdef PIPE_REG_PERF_EN
    check("rsb_scnt",   stall_cnt, 64'h0);
    check("rsb_bcnt",   bubble_cnt, 64'h0);
`endif

    // reset in the middle of a stall
    reset = 1'b0; stall = 1'b0; bubble = 1'b0;
    drive(3'h1, 4'h2, 4'h0, 64'h0, 64'h44, 64'h0, 4'h5, 4'h6, 4'h7, 4'h8);
    tick();
    check("pre_icode", out_icode, 64'h2);
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("rms_icode", out_icode, 64'h1);
    check("rms_valA",  out_valA, 64'h0);
    check("rms_err",   ctl_err, 64'h0);

`ifdef PIPE_REG_PERF_EN
    // stall counter saturates at all-ones and holds
    reset = 1'b0; stall = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("sat_scnt", stall_cnt, 64'hF);
    tick();
    check("sat_hold", stall_cnt, 64'hF);
    reset = 1'b1;
    tick();
    check("sat_rst",  stall_cnt, 64'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
